// File: rtl/shr_cap_pkg.sv
// rtl/shr_cap_pkg.sv - shared types and defaults for the shift-register frame capture block
package shr_cap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

  localparam int DEF_MAX_LEN = 1024;
  localparam int DEF_CNT_W   = 11;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with a registered rising-edge pulse
module sync_edge_det
  import shr_cap_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    // Pulse is registered so it lines up one cycle after the level it was derived from.
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;

endmodule

// File: rtl/shr_frame_capture.sv
// rtl/shr_frame_capture.sv - oversampling capture of a serial shift-register frame into a parallel register
// Optional data-compare against the transmitted pattern is enabled by SHR_CAP_COMPARE_EN.
module shr_frame_capture
  import shr_cap_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               shr_clk,
  input  logic               shr_syn,
  input  logic               shr_din,
  input  logic [9:0]         seq_length,
  input  logic               arm,
  output logic               busy,
  output logic               done,
  output logic               len_err,
  output logic               overflow,
  output logic [CNT_W-1:0]   bit_cnt,
`ifdef SHR_CAP_COMPARE_EN
  input  logic [MAX_LEN-1:0] exp_reg,
  output logic               mismatch,
  output logic [CNT_W-1:0]   err_cnt,
`endif
  output logic [MAX_LEN-1:0] cap_reg
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMP_W = (CNT_W > 10) ? CNT_W : 10;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  logic clk_rise, syn_lvl, din_lvl;
  logic unused_clk_lvl, unused_syn_rise, unused_din_rise;

  sync_edge_det u_clk_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (shr_clk),
    .level    (unused_clk_lvl),
    .rise     (clk_rise)
  );

  sync_edge_det u_syn_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (shr_syn),
    .level    (syn_lvl),
    .rise     (unused_syn_rise)
  );

  sync_edge_det u_din_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (shr_din),
    .level    (din_lvl),
    .rise     (unused_din_rise)
  );

  cap_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               done_q, done_d;
  logic               len_err_q, len_err_d;
  logic               overflow_q, overflow_d;
  logic [IDX_W-1:0]   wr_idx;
`ifdef SHR_CAP_COMPARE_EN
  logic               mismatch_q, mismatch_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cap_d      = cap_q;
    done_d     = done_q;
    len_err_d  = len_err_q;
    overflow_d = overflow_q;
    wr_idx     = bit_cnt_q[IDX_W-1:0];
`ifdef SHR_CAP_COMPARE_EN
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;
`endif

    // arm outranks every line event, including a capture or frame end in the same cycle.
    if (arm) begin
      state_d    = WAIT_SYNC;
      bit_cnt_d  = '0;
      cap_d      = '0;
      done_d     = 1'b0;
      len_err_d  = 1'b0;
      overflow_d = 1'b0;
`ifdef SHR_CAP_COMPARE_EN
      mismatch_d = 1'b0;
      err_cnt_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: ;
        WAIT_SYNC: begin
          if (syn_lvl) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            if (bit_cnt_q < MAX_CNT) begin
              cap_d[wr_idx] = din_lvl;
              bit_cnt_d     = bit_cnt_q + 1'b1;
`ifdef SHR_CAP_COMPARE_EN
              if (din_lvl != exp_reg[wr_idx]) begin
                mismatch_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
              end
`endif
            end else begin
              overflow_d = 1'b1;
            end
          end
          // A bit arriving with the sync fall still counts toward this frame.
          if (!syn_lvl) begin
            state_d   = DONE;
            done_d    = 1'b1;
            len_err_d = (CMP_W'(bit_cnt_d) != CMP_W'(seq_length)) || overflow_d;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cap_q      <= '0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SHR_CAP_COMPARE_EN
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cap_q      <= cap_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
      overflow_q <= overflow_d;
`ifdef SHR_CAP_COMPARE_EN
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign busy     = (state_q == WAIT_SYNC) || (state_q == SHIFT);
  assign done     = done_q;
  assign len_err  = len_err_q;
  assign overflow = overflow_q;
  assign bit_cnt  = bit_cnt_q;
  assign cap_reg  = cap_q;
`ifdef SHR_CAP_COMPARE_EN
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_shr_frame_capture.sv
// tb/tb_shr_frame_capture.sv - randomized self-checking bench for shr_frame_capture
module tb_shr_frame_capture;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;

  logic               clk_in = 1'b0;
  logic               rst_n = 1'b0;
  logic               shr_clk = 1'b0;
  logic               shr_syn = 1'b0;
  logic               shr_din = 1'b0;
  logic               arm = 1'b0;
  logic [9:0]         seq_length = '0;
  logic               busy, done, len_err, overflow;
  logic [CNT_W-1:0]   bit_cnt;
  logic [MAX_LEN-1:0] cap_reg;
`ifdef SHR_CAP_COMPARE_EN
  logic [MAX_LEN-1:0] exp_reg = '0;
  logic               mismatch;
  logic [CNT_W-1:0]   err_cnt;
`endif

  always #5 clk_in = ~clk_in;

  shr_frame_capture #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .shr_clk    (shr_clk),
    .shr_syn    (shr_syn),
    .shr_din    (shr_din),
    .seq_length (seq_length),
    .arm        (arm),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err),
    .overflow   (overflow),
    .bit_cnt    (bit_cnt),
`ifdef SHR_CAP_COMPARE_EN
    .exp_reg    (exp_reg),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
`endif
    .cap_reg    (cap_reg)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: pin samples per clk_in edge; edge seen 3 cycles late, levels 2 late.
  bit hc[4], hs[4], hd[4];
  bit m_wait, m_shift, m_fin, m_len_err;
  bit m_e, m_d, m_s;
  int n_edges;
  int m_mis;
  bit q[$];

  function automatic int m_cnt();
    return (n_edges > MAX_LEN) ? MAX_LEN : n_edges;
  endfunction

  function automatic logic [63:0] m_cap();
    logic [63:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin hc[i] = 0; hs[i] = 0; hd[i] = 0; end
      m_wait = 0; m_shift = 0; m_fin = 0; m_len_err = 0;
      n_edges = 0; m_mis = 0; q.delete();
    end else begin
      m_e = hc[2] & ~hc[3];
      m_d = hd[1];
      m_s = hs[1];
      if (arm) begin
        q.delete(); n_edges = 0; m_mis = 0;
        m_wait = 1; m_shift = 0; m_fin = 0; m_len_err = 0;
      end else if (m_wait) begin
        if (m_s) begin m_wait = 0; m_shift = 1; end
      end else if (m_shift) begin
        if (m_e) begin
          if (n_edges < MAX_LEN) begin
            q.push_back(m_d);
`ifdef SHR_CAP_COMPARE_EN
            if (m_d != exp_reg[n_edges]) m_mis++;
`endif
          end
          n_edges++;
        end
        if (!m_s) begin
          m_shift = 0; m_fin = 1;
          m_len_err = (m_cnt() != int'(seq_length)) || (n_edges > MAX_LEN);
        end
      end
      for (int i = 3; i > 0; i--) begin hc[i] = hc[i-1]; hs[i] = hs[i-1]; hd[i] = hd[i-1]; end
      hc[0] = shr_clk; hs[0] = shr_syn; hd[0] = shr_din;
    end
  end

  always @(posedge clk_in) begin
    #1;
    chk("busy", busy, m_wait | m_shift);
    chk("done", done, m_fin);
    chk("len_err", len_err, m_len_err);
    chk("overflow", overflow, n_edges > MAX_LEN);
    chk("bit_cnt", bit_cnt, m_cnt());
    chk("cap_reg", cap_reg, m_cap());
`ifdef SHR_CAP_COMPARE_EN
    chk("mismatch", mismatch, m_mis > 0);
    chk("err_cnt", err_cnt, m_mis);
`endif
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic send_bit(input bit b, input int half);
    shr_din = b;
    cyc(half);
    shr_clk = 1'b1;
    cyc(half);
    shr_clk = 1'b0;
  endtask

  // tail: cycles from the last rising shift clock to sync fall; abort_at: bit index to re-arm at.
  task automatic send_frame(input logic [31:0] data, input int len, input int half,
                            input int tail, input int abort_at);
    shr_syn = 1'b1;
    cyc(half);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) arm_pulse();
      shr_din = data[i];
      cyc(half);
      shr_clk = 1'b1;
      if (i == len - 1) begin
        cyc(tail);
        shr_syn = 1'b0;
        cyc(half);
      end else begin
        cyc(half);
      end
      shr_clk = 1'b0;
    end
    if (len == 0) shr_syn = 1'b0;
    cyc(6);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk_in);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Reset in the middle of a frame, then a clean 4-bit frame.
    seq_length = 10'd4;
    arm_pulse();
    shr_syn = 1'b1;
    cyc(4);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 4);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_cap", cap_reg, 0);
    shr_syn = 1'b0;
    shr_din = 1'b0;
    rst_n = 1'b1;
    cyc(3);
    arm_pulse();
    send_frame(32'h9, 4, 3, 3, -1);
    chk("t1_bit_cnt", bit_cnt, 4);
    chk("t1_cap", cap_reg, 16'h0009);
    chk("t1_len_err", len_err, 0);

    // Nominal 8-bit frame, shift clock period 8.
    seq_length = 10'd8;
    arm_pulse();
    send_frame(32'h4D, 8, 4, 4, -1);
    chk("t2_done", done, 1);
    chk("t2_bit_cnt", bit_cnt, 8);
    chk("t2_cap", cap_reg, 16'h004D);
    chk("t2_len_err", len_err, 0);
    chk("t2_busy", busy, 0);
    chk("t2_model_cap", m_cap(), 64'h4D);

    // Short frame, then re-arm clears results within one cycle.
    arm_pulse();
    send_frame(32'h2A, 6, 3, 3, -1);
    chk("t3_done", done, 1);
    chk("t3_bit_cnt", bit_cnt, 6);
    chk("t3_len_err", len_err, 1);
    chk("t3_model_len_err", m_len_err, 1);
    arm_pulse();
    chk("t3_rearm_done", done, 0);
    chk("t3_rearm_len_err", len_err, 0);
    chk("t3_rearm_cap", cap_reg, 0);

    // Overflow: 20 edges into a 16-bit capture register.
    seq_length = 10'd16;
    send_frame(32'hFFFFF, 20, 2, 2, -1);
    chk("t4_cap", cap_reg, 16'hFFFF);
    chk("t4_bit_cnt", bit_cnt, 16);
    chk("t4_overflow", overflow, 1);
    chk("t4_len_err", len_err, 1);
    chk("t4_model_edges", n_edges, 20);

    // Abort after bit 3, then a fresh 2-bit frame.
    seq_length = 10'd2;
    arm_pulse();
    shr_syn = 1'b1;
    cyc(3);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 3);
    shr_syn = 1'b0;
    cyc(1);
    arm_pulse();
    cyc(4);
    chk("t5_no_done", done, 0);
    chk("t5_busy", busy, 1);
    send_frame(32'h3, 2, 3, 3, -1);
    chk("t5_bit_cnt", bit_cnt, 2);
    chk("t5_cap", cap_reg, 16'h0003);
    chk("t5_done", done, 1);

`ifdef SHR_CAP_COMPARE_EN
    exp_reg = 16'h00FF;
    seq_length = 10'd8;
    arm_pulse();
    send_frame(32'h0F, 8, 4, 4, -1);
    chk("t6_mismatch", mismatch, 1);
    chk("t6_err_cnt", err_cnt, 4);
    chk("t6_model_mis", m_mis, 4);
`endif

    // Randomized frames: lengths, rates, tail timing, early sync, aborts.
    for (int it = 0; it < 40; it++) begin
      int len, half, tail, abort_at, variant;
      logic [31:0] data;
      len = $urandom_range(0, 20);
      half = $urandom_range(2, 5);
      tail = $urandom_range(1, half);
      data = $urandom;
      variant = $urandom_range(0, 3);
      abort_at = (variant == 2 && len > 1) ? $urandom_range(1, len - 1) : -1;
      seq_length = ($urandom_range(0, 1) == 1) ? 10'(len) : 10'($urandom_range(0, 20));
`ifdef SHR_CAP_COMPARE_EN
      exp_reg = 16'($urandom);
`endif
      if (variant == 1) begin
        shr_syn = 1'b1;
        cyc(3);
      end
      arm_pulse();
      send_frame(data, len, half, tail, abort_at);
    end

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shr_frame_capture.md
Name: shr_frame_capture

Overview:
Capture stage that sits directly downstream of the serial frame transmitter feeding the external shift-register chain. It oversamples the transmitted shift clock, sync and data lines (or the chain's returned serial output) in the clk_in domain and reassembles each frame into a parallel capture register. It also reports frame bit count, completion and length/overflow errors, so the host can read back and check what went out on GPIO.

Parameters:
MAX_LEN, 1024, capacity of the capture register in bits.
CNT_W, 11, width of the bit counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
clk_in  input  1  sampling clock; must be at least 4x the shift clock frequency.
rst_n  input  1  reset, asynchronous assert, active-low.
shr_clk  input  1  serial shift clock from the line, asynchronous to clk_in.
shr_syn  input  1  frame sync, active-high, asynchronous.
shr_din  input  1  serial data, asynchronous.
seq_length  input  10  expected frame length in bits; 0 means expect 0 bits.
arm  input  1  single-cycle pulse that starts a new capture.
busy  output  1  high in WAIT_SYNC or SHIFT.
done  output  1  sticky; set at frame end, cleared by arm.
len_err  output  1  sticky; bit_cnt differs from seq_length at frame end.
overflow  output  1  sticky; more than MAX_LEN clock edges seen in one frame.
bit_cnt  output  CNT_W  bits received in the current or last frame; saturates at MAX_LEN.
cap_reg  output  MAX_LEN  captured data; the first received bit goes to cap_reg[0].

Behaviour:
- Reset: clock is clk_in. Reset is asynchronous and active-low on rst_n. All outputs and the synchronizers reset to 0. State resets to IDLE.
- Input path: shr_clk, shr_syn and shr_din each pass through a 2-flop synchronizer.
- A clock edge is the registered rising-edge detect of synchronized shr_clk (sync_q & ~sync_qq). The edge pulse occurs 3 clk_in cycles after the pin transition.
- Data is sampled from synchronized shr_din in the same cycle as the edge pulse. Setup at the pin is therefore guaranteed when the transmitter changes data on the falling edge.
- States:
  - IDLE: waits for arm; then goes to WAIT_SYNC.
  - WAIT_SYNC: on synchronized syn = 1, goes to SHIFT. A clock edge seen here is ignored.
  - SHIFT: on each edge, if bit_cnt < MAX_LEN, write cap_reg[bit_cnt] <= din and increment bit_cnt. Otherwise set overflow and hold bit_cnt. When synchronized syn = 0, go to DONE.
  - DONE: done = 1. len_err = (bit_cnt != seq_length) || overflow, computed in the SHIFT->DONE transition cycle. Stays in DONE until arm.
- arm handling: arm in any state clears done, len_err, overflow, bit_cnt and cap_reg (all to 0) in the next cycle, then enters WAIT_SYNC. arm during SHIFT aborts the current frame; no done is produced.
- Simultaneous edge and syn fall in the same cycle: the bit is captured first (counts), then the FSM goes to DONE in that same cycle.
- Simultaneous arm and any event: arm wins.
- syn already high when armed: SHIFT is entered immediately. This is a legal mid-frame start; len_err will flag the short frame.
- seq_length is sampled only at frame end.
- busy = (state == WAIT_SYNC) || (state == SHIFT).
- Reset mid-frame: immediate return to IDLE with outputs cleared.

Optional Feature:
- Macro: SHR_CAP_COMPARE_EN.
- With it defined:
  - Extra input exp_reg [MAX_LEN-1:0], the data handed to the transmitter.
  - Extra outputs mismatch (1, sticky) and err_cnt (CNT_W).
  - On each captured bit, compare din with exp_reg[bit_cnt]. On inequality, increment err_cnt (saturating) and set mismatch.
  - Both outputs are cleared by arm and reset.
- Without it: those ports and the compare logic do not exist; all other behaviour is identical.

Decomposition:
- Package shr_cap_pkg holds:
  - state encoding (IDLE=2'd0, WAIT_SYNC=2'd1, SHIFT=2'd2, DONE=2'd3);
  - default MAX_LEN and CNT_W;
  - SYNC_STAGES = 2.
- Sub-module sync_edge_det: 2-flop synchronizer plus a registered rising-edge pulse output, with the same clk_in/rst_n. It is instantiated for shr_clk (edge used) and for shr_syn/shr_din (level output only).

Test Plan:
1. Reset during SHIFT after 5 bits -> all outputs 0, state IDLE; after reset release, arm plus a 4-bit frame captures correctly.
2. seq_length=8, arm, frame 8 bits 1,0,1,1,0,0,1,0 with shr_clk period 8 clk_in -> done=1, bit_cnt=8, cap_reg[7:0]=8'h4D, len_err=0, busy=0.
3. seq_length=8, frame of 6 bits -> done=1, bit_cnt=6, len_err=1; a second arm clears done, len_err and cap_reg within 1 cycle.
4. MAX_LEN=16, seq_length=16, 20 edges of data 1 -> cap_reg=16'hFFFF, bit_cnt=16, overflow=1, len_err=1.
5. arm pulse after bit 3 of a frame, then syn falls and a fresh 2-bit frame (1,1) follows -> only the new frame is captured: bit_cnt=2, cap_reg[1:0]=2'b11, no done before it.
6. SHR_CAP_COMPARE_EN with exp_reg[7:0]=8'hFF and frame 8'h0F -> mismatch=1, err_cnt=4; without the macro, scenario 2 still passes.
